// File: rtl/count_sequencer.sv
// Run/stop/clear sequencer for a two-digit tick-driven counter shown on LED as {MSD, LSD}.
// Optional down-count support is compiled in with COUNT_SEQ_DOWN_EN.
module count_sequencer #(
    parameter int unsigned PERIOD_W    = 30,
    parameter int unsigned AUTO_RELOAD = 1
) (
    input  logic                CLK_50M,
    input  logic                RST_N,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic [PERIOD_W-1:0] period,
    input  logic [3:0]          limit,
`ifdef COUNT_SEQ_DOWN_EN
    input  logic                down,
`endif
    output logic [7:0]          LED,
    output logic                tick,
    output logic                wrap,
    output logic                running,
    output logic [1:0]          state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t              st_q;
    logic [PERIOD_W-1:0] presc_q;
    logic [3:0]          msd_q;
    logic [3:0]          lsd_q;
    logic [3:0]          lim_q;
`ifdef COUNT_SEQ_DOWN_EN
    logic                dir_q;
`endif

    logic [3:0]          lim_clamp;
    logic [3:0]          lim_top;
    logic [PERIOD_W-1:0] presc_top;
    logic                presc_hit;

    // >= rather than == so a shrinking period wraps at once instead of overrunning
    always_comb begin
        lim_clamp = (limit < 4'd2) ? 4'd2 : limit;
        lim_top   = lim_q - 4'd1;
        presc_top = (period == '0) ? '0 : period - PERIOD_W'(1);
        presc_hit = (presc_q >= presc_top);
    end

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            st_q    <= ST_IDLE;
            presc_q <= '0;
            msd_q   <= '0;
            lsd_q   <= '0;
            lim_q   <= 4'd10;
            tick    <= 1'b0;
            wrap    <= 1'b0;
`ifdef COUNT_SEQ_DOWN_EN
            dir_q   <= 1'b0;
`endif
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clear) begin
                st_q    <= ST_IDLE;
                presc_q <= '0;
                msd_q   <= '0;
                lsd_q   <= '0;
            end else if (stop) begin
                if (st_q == ST_RUN) begin
                    st_q <= ST_PAUSE;
                end
            end else if (start && (st_q != ST_RUN)) begin
                st_q <= ST_RUN;
                // resume from PAUSE keeps prescaler, digits and modulus untouched
                if (st_q != ST_PAUSE) begin
                    lim_q   <= lim_clamp;
                    presc_q <= '0;
`ifdef COUNT_SEQ_DOWN_EN
                    dir_q <= down;
                    if (down) begin
                        msd_q <= lim_clamp - 4'd1;
                        lsd_q <= lim_clamp - 4'd1;
                    end else if (st_q == ST_DONE) begin
                        msd_q <= '0;
                        lsd_q <= '0;
                    end
`else
                    if (st_q == ST_DONE) begin
                        msd_q <= '0;
                        lsd_q <= '0;
                    end
`endif
                end
            end else if (st_q == ST_RUN) begin
                if (presc_hit) begin
                    presc_q <= '0;
                    tick    <= 1'b1;
`ifdef COUNT_SEQ_DOWN_EN
                    if (dir_q) begin
                        // terminal count is the 01 -> 00 step; 00 reloads max on the next step
                        if ((msd_q == 4'd0) && (lsd_q == 4'd1)) begin
                            lsd_q <= 4'd0;
                            wrap  <= 1'b1;
                            if (AUTO_RELOAD == 0) begin
                                st_q <= ST_DONE;
                            end
                        end else if (lsd_q == 4'd0) begin
                            lsd_q <= lim_top;
                            msd_q <= (msd_q == 4'd0) ? lim_top : msd_q - 4'd1;
                        end else begin
                            lsd_q <= lsd_q - 4'd1;
                        end
                    end else
`endif
                    begin
                        if (lsd_q == lim_top) begin
                            if (msd_q == lim_top) begin
                                wrap <= 1'b1;
                                if (AUTO_RELOAD != 0) begin
                                    msd_q <= '0;
                                    lsd_q <= '0;
                                end else begin
                                    st_q <= ST_DONE;
                                end
                            end else begin
                                lsd_q <= '0;
                                msd_q <= msd_q + 4'd1;
                            end
                        end else begin
                            lsd_q <= lsd_q + 4'd1;
                        end
                    end
                end else begin
                    presc_q <= presc_q + PERIOD_W'(1);
                end
            end
        end
    end

    assign LED     = {msd_q, lsd_q};
    assign running = (st_q == ST_RUN);
    assign state   = st_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: one auto-reloading instance and one stop-at-done instance.
module tb_count_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        clear;
    logic [29:0] period;
    logic [3:0]  limit;
    logic        down;
    logic [7:0]  led1, led2;
    logic        tick1, tick2, wrap1, wrap2, running1, running2;
    logic [1:0]  state1, state2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [7:0] led;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   w;

    count_sequencer #(.PERIOD_W(30), .AUTO_RELOAD(1)) u_dut (
        .CLK_50M(clk), .RST_N(rst_n), .start(start), .stop(stop), .clear(clear),
        .period(period), .limit(limit),
`ifdef COUNT_SEQ_DOWN_EN
        .down(down),
`endif
        .LED(led1), .tick(tick1), .wrap(wrap1), .running(running1), .state(state1)
    );

    count_sequencer #(.PERIOD_W(30), .AUTO_RELOAD(0)) u_dut_nr (
        .CLK_50M(clk), .RST_N(rst_n), .start(start), .stop(stop), .clear(clear),
        .period(period), .limit(limit),
`ifdef COUNT_SEQ_DOWN_EN
        .down(down),
`endif
        .LED(led2), .tick(tick2), .wrap(wrap2), .running(running2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] to_led(input int v, input int lim);
        return {4'(v / lim), 4'(v % lim)};
    endfunction

    // called at a negedge; command is sampled on the following posedge
    task automatic pulse(input logic s, input logic p, input logic c);
        start = s; stop = p; clear = c;
        @(negedge clk);
        start = 1'b0; stop = 1'b0; clear = 1'b0;
    endtask

    // returns the number of cycles until the selected tick, budget+1 on timeout
    task automatic wait_tick(input int sel, input int budget, output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while ((((sel == 1) ? tick1 : tick2) !== 1'b1) && (waited <= budget));
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        period = 30'd3; limit = 4'd10; down = 1'b0;
        #2;
        checks++; if (led1 !== 8'h00) begin errors++; $display("FAIL reset_led: got %h expected 00", led1); end
        checks++; if (state1 !== 2'b00) begin errors++; $display("FAIL reset_state: got %b expected 00", state1); end
        @(negedge clk);
        checks++; if ({tick1, wrap1, running1} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {tick1, wrap1, running1}); end
        checks++; if (state2 !== 2'b00) begin errors++; $display("FAIL reset_state_nr: got %b expected 00", state2); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_bcd_run();
        period = 30'd3; limit = 4'd10;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        for (int v = 1; v <= 100; v++) sb.push_back('{to_led(v % 100, 10), v == 100});
        checks++; if ({running1, state1} !== 3'b101) begin errors++; $display("FAIL bcd_start: got %b expected 101", {running1, state1}); end
        for (int i = 0; i < 100; i++) begin
            wait_tick(1, 5, w);
            e = sb.pop_front();
            checks++; if (w !== 3) begin errors++; $display("FAIL bcd_gap step %0d: got %0d expected 3", i + 1, w); end
            checks++; if ({led1, wrap1} !== {e.led, e.wrap}) begin errors++; $display("FAIL bcd_step %0d: got %h/%b expected %h/%b", i + 1, led1, wrap1, e.led, e.wrap); end
        end
    endtask

    task automatic test_no_reload();
        period = 30'd1; limit = 4'd4;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        for (int v = 1; v <= 16; v++) sb.push_back('{to_led((v == 16) ? 15 : v, 4), v == 16});
        for (int i = 0; i < 16; i++) begin
            wait_tick(2, 3, w);
            e = sb.pop_front();
            checks++; if (w !== 1) begin errors++; $display("FAIL nr_gap step %0d: got %0d expected 1", i + 1, w); end
            checks++; if ({led2, wrap2} !== {e.led, e.wrap}) begin errors++; $display("FAIL nr_step %0d: got %h/%b expected %h/%b", i + 1, led2, wrap2, e.led, e.wrap); end
        end
        checks++; if (state2 !== 2'b11) begin errors++; $display("FAIL nr_done_state: got %b expected 11", state2); end
        repeat (3) @(negedge clk);
        checks++; if ({led2, tick2} !== {8'h33, 1'b0}) begin errors++; $display("FAIL nr_hold: got %h/%b expected 33/0", led2, tick2); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if ({state2, led2} !== {2'b01, 8'h00}) begin errors++; $display("FAIL nr_restart: got %b/%h expected 01/00", state2, led2); end
        wait_tick(2, 3, w);
        checks++; if ({w[3:0], led2} !== {4'd1, 8'h01}) begin errors++; $display("FAIL nr_restart_step: got %0d/%h expected 1/01", w, led2); end
    endtask

    task automatic test_pause_resume();
        logic saw_tick;
        period = 30'd5; limit = 4'd10;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        for (int v = 1; v <= 6; v++) sb.push_back('{to_led(v, 10), 1'b0});
        for (int i = 0; i < 5; i++) begin
            wait_tick(1, 7, w);
            e = sb.pop_front();
            checks++; if ({w[3:0], led1} !== {4'd5, e.led}) begin errors++; $display("FAIL pause_pre %0d: got %0d/%h expected 5/%h", i + 1, w, led1, e.led); end
        end
        repeat (2) @(negedge clk);
        pulse(1'b0, 1'b1, 1'b0);
        checks++; if ({running1, state1} !== 3'b010) begin errors++; $display("FAIL pause_state: got %b expected 010", {running1, state1}); end
        saw_tick = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tick1) saw_tick = 1'b1;
        end
        checks++; if ({led1, saw_tick} !== {8'h05, 1'b0}) begin errors++; $display("FAIL pause_hold: got %h/%b expected 05/0", led1, saw_tick); end
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (state1 !== 2'b01) begin errors++; $display("FAIL resume_state: got %b expected 01", state1); end
        wait_tick(1, 7, w);
        e = sb.pop_front();
        checks++; if ({w[3:0], led1} !== {4'd3, e.led}) begin errors++; $display("FAIL resume_gap: got %0d/%h expected 3/%h", w, led1, e.led); end
    endtask

    task automatic test_priority_mod2();
        pulse(1'b1, 1'b1, 1'b1);
        checks++; if ({state1, led1, running1} !== {2'b00, 8'h00, 1'b0}) begin errors++; $display("FAIL prio_clear: got %b/%h/%b expected 00/00/0", state1, led1, running1); end
        limit = 4'd0; period = 30'd1;
        pulse(1'b1, 1'b0, 1'b0);
        for (int v = 1; v <= 4; v++) sb.push_back('{to_led(v % 4, 2), v == 4});
        checks++; if (running1 !== 1'b1) begin errors++; $display("FAIL mod2_start: got %b expected 1", running1); end
        for (int i = 0; i < 4; i++) begin
            wait_tick(1, 3, w);
            e = sb.pop_front();
            checks++; if ({w[3:0], led1, wrap1} !== {4'd1, e.led, e.wrap}) begin errors++; $display("FAIL mod2_step %0d: got %0d/%h/%b expected 1/%h/%b", i + 1, w, led1, wrap1, e.led, e.wrap); end
        end
    endtask

`ifdef COUNT_SEQ_DOWN_EN
    task automatic test_down();
        int v;
        down = 1'b1; limit = 4'd10; period = 30'd1;
        pulse(1'b0, 1'b0, 1'b1);
        pulse(1'b1, 1'b0, 1'b0);
        checks++; if (led1 !== 8'h99) begin errors++; $display("FAIL down_preload: got %h expected 99", led1); end
        v = 99;
        for (int i = 0; i < 100; i++) begin
            sb.push_back('{to_led((v == 0) ? 99 : v - 1, 10), v == 1});
            v = (v == 0) ? 99 : v - 1;
        end
        for (int i = 0; i < 100; i++) begin
            wait_tick(1, 3, w);
            e = sb.pop_front();
            checks++; if ({w[3:0], led1, wrap1} !== {4'd1, e.led, e.wrap}) begin errors++; $display("FAIL down_step %0d: got %0d/%h/%b expected 1/%h/%b", i + 1, w, led1, wrap1, e.led, e.wrap); end
        end
        down = 1'b0;
    endtask
`endif

    task automatic test_async_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({led1, state1, tick1} !== {8'h00, 2'b00, 1'b0}) begin errors++; $display("FAIL async_reset: got %h/%b/%b expected 00/00/0", led1, state1, tick1); end
        checks++; if ({led2, state2, tick2} !== {8'h00, 2'b00, 1'b0}) begin errors++; $display("FAIL async_reset_nr: got %h/%b/%b expected 00/00/0", led2, state2, tick2); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_bcd_run();
        test_no_reload();
        test_pause_resume();
        test_priority_mod2();
`ifdef COUNT_SEQ_DOWN_EN
        test_down();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_sequencer.md
Name: count_sequencer

Overview:
Run/stop/clear controller for the two-digit tick-driven counter datapath on the LED bank.
- Owns the tick prescaler and both digit registers; sequences them through an idle/run/pause/done state machine.
- Drives LED[7:0] as {MSD, LSD}, one 4-bit digit per nibble.
- Sits between board push-buttons (already synchronised and pulse-shaped upstream) and the LED outputs, replacing free-running divider-plus-counter chains.

Parameters:
- PERIOD_W, 30, width of the period input and the prescaler register.
- AUTO_RELOAD, 1, 1 = wrap to 00 at terminal count and keep running; 0 = stop in DONE.

Ports:
- CLK_50M  input  1  system clock, 50 MHz.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse: start or resume.
- stop  input  1  one-cycle pulse: pause.
- clear  input  1  one-cycle pulse: return to IDLE and zero all counters.
- period  input  PERIOD_W  clock cycles per tick; 0 is treated as 1.
- limit  input  4  digit modulus; 10 gives BCD 00..99; values 0 and 1 are treated as 2.
- LED  output  8  {MSD, LSD}.
- tick  output  1  one-cycle pulse on each count step.
- wrap  output  1  one-cycle pulse on terminal count.
- running  output  1  high in RUN.
- state  output  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.

Behaviour:
- Reset (RST_N low, asynchronous): state=IDLE, prescaler=0, LED=8'h00, tick=0, wrap=0, running=0, lim_q=10.
- Command priority in any state: clear > stop > start. Simultaneous commands resolve to the highest priority only.
- clear: next edge gives state=IDLE, prescaler=0, digits=0. tick and wrap stay 0 on that edge.
- IDLE + start: lim_q <= clamp(limit), prescaler <= 0, state <= RUN. The digits keep their value (0 after clear).
- RUN + stop: state <= PAUSE; prescaler and digits freeze.
- PAUSE + start: state <= RUN; prescaler resumes from its frozen value. limit is not resampled.
- DONE + start: digits <= 00, prescaler <= 0, lim_q resampled, state <= RUN.
- start in RUN, and stop in IDLE, PAUSE or DONE: ignored.
- Prescaler, only in RUN:
  - if prescaler == max(period,1)-1: prescaler <= 0 and tick <= 1 on the same edge.
  - otherwise prescaler increments.
  - Result: tick period = max(period,1) cycles; period=1 gives tick every cycle.
- period is read live; a change mid-run takes effect on the next comparison. If the prescaler is already >= the new period-1, it must wrap at the next comparison; it must never overrun to 2^PERIOD_W.
- Digit step, on the same edge as tick:
  - LSD increments; at lim_q-1 it goes to 0 and carries into MSD.
  - MSD at lim_q-1 with a carry means terminal count.
- Terminal count (LED == {lim_q-1, lim_q-1} at a step): wrap <= 1.
  - AUTO_RELOAD=1: digits <= 00, stay in RUN.
  - AUTO_RELOAD=0: digits hold at terminal value, state <= DONE, prescaler <= 0.
- Latency:
  - LED, tick and wrap all change on the same edge; registered outputs, no combinational path from inputs.
  - running and state update one edge after the command pulse.
- limit changes while in RUN or PAUSE are ignored until the next IDLE/DONE start.

Optional Feature:
- Macro: COUNT_SEQ_DOWN_EN.
- Defined:
  - Adds input port down (1 bit), sampled into dir_q at every start that leaves IDLE or DONE.
  - dir_q=1: the start from IDLE/DONE preloads digits to {lim_q-1, lim_q-1}. Each step decrements; LSD borrows at 0. Terminal count is 00 reached from 01.
  - AUTO_RELOAD=1 reloads max; AUTO_RELOAD=0 goes to DONE holding 00.
- Undefined: no down port; up-count only, identical to the rules above.

Test Plan:
- Reset mid-run (RST_N low between edges): LED=00, state=00, tick=0 immediately, with no clock edge.
- period=3, limit=10, start: tick every 3 cycles; LED steps 00,01..09,10; after 99 steps LED=8'h99. Step 100 pulses wrap and gives LED=00 (AUTO_RELOAD=1).
- AUTO_RELOAD=0, period=1, limit=4: 15 ticks reach LED=8'h33; the next tick pulses wrap, state=11, LED holds 33; start then restarts from 00.
- Run to LED=8'h05 with period=5, stop 2 cycles after a tick, wait 20 cycles, start: LED stays 05 while paused. The next tick arrives exactly 3 cycles after the resume.
- Simultaneous start+stop+clear in RUN: state=IDLE, LED=00. Then limit=0 with start: counting uses modulus 2 (00,01,10,11,00).
- COUNT_SEQ_DOWN_EN defined, down=1, limit=10, period=1: LED sequence 99,98..00. wrap pulses on the 00 step, then the count reloads 99.
